hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Tracks destination registers of instructions in flight between decode and writeback, the opposite direction from the decode-to-execute pipeline register. Instructions flow forward through that register; this block sends hazard status back to decode. It mirrors the EX, MEM and WB occupancy in a three-entry shift pipeline. Each cycle it tells the decode stage whether the instruction being issued must stall and, when forwarding is compiled in, which stage supplies each operand.

## Interface
- `WIDTH`, 32: datapath width; fixed from the shared parameter set, sets register-file addressing context.
- `REG_ADDR_W`, 5: register index width.
- `DEPTH`, 3: tracked stages (0 = EX, 1 = MEM, 2 = WB).
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `issue_valid` input 1: decode presents an instruction this cycle.
- `issue_dst` input REG_ADDR_W: destination register of the issued instruction.
- `issue_writes` input 1: the issued instruction writes `issue_dst`.
- `issue_is_load` input 1: the issued instruction is a load (result available only after MEM).
- `src_a`, `src_b` input REG_ADDR_W: source registers of the decoding instruction.
- `src_a_used`, `src_b_used` input 1: the corresponding source is read.
- `hold` input 1: downstream freeze (memory wait); pipeline does not advance.
- `flush` input 1: squash the instruction currently in decode.
- `stall` output 1: decode must not advance; combinational.
- `fwd_a_sel`, `fwd_b_sel` output 2: 00 regfile, 01 EX, 10 MEM, 11 WB; combinational.
- `inflight` output 2: count of valid tracked entries; registered.

## Operation
- Each entry holds valid, dst, and is_load. An entry participates in hazard checks only if it is valid, its writes flag was set, and its dst is not 0. Register 0 is never a hazard.
- A source matches if it is used, is not 0, and equals a participating entry's dst. When several entries match, the youngest entry wins: EX, then MEM, then WB.
- `stall` = `hold` OR `flush`-free hazard (hazard rules per Configuration). `flush` forces `stall`=0 contribution from hazards; the squashed instruction is not checked.
- Advance (on `hold`=0): entry2 takes entry1's value, and entry1 takes entry0's value. Entry0 takes the issued instruction if `issue_valid` AND NOT `stall` AND NOT `flush`; otherwise entry0 becomes a bubble (valid=0).
- When `hold`=1, all entries keep their values and `stall`=1.
- `fwd_*_sel` = 00 whenever `stall`=1 or without forwarding.

## Timing
- Reset (async, `rst_n`=0): all entries invalid and `inflight`=0. Combinational outputs follow, so with `hold`=0: `stall`=0 and `fwd_*_sel`=00.
- `stall` and `fwd_*_sel` are valid in the same cycle as the sources; there is zero latency.
- An issued instruction appears in entry0 on the next rising edge. It retires from tracking three advancing edges later.
- Simultaneous `flush` and `hold`: `hold` dominates, so nothing shifts and the flush is ignored by this block. Decode re-presents the instruction.
- `rst_n` deasserted mid-stream: all in-flight tracking is lost, and decode must be flushed alongside.

## Configuration
- `HAZARD_FORWARD_EN` defined: `stall` is raised only for load-use. This is when the youngest match is entry0 with is_load=1. Otherwise `fwd_*_sel` selects the youngest matching stage.
- Undefined: any match in any entry raises `stall`, and `fwd_*_sel` is tied to 00.

## Structure
- Shared package: `FWD_REGFILE/EX/MEM/WB` encodings, stage index constants, and the entry record typedef (valid, writes, is_load, dst).
- One sub-module `hazard_match`: compares one source against all entries and returns hit and youngest-stage index. It is instantiated once per source.

## Test plan
- Reset with `rst_n`=0, then release; `src_a`=5 used -> `stall`=0, `fwd_a_sel`=00, `inflight`=0.
- Issue ADD r3 (writes), next cycle src_a=3. With forwarding: `stall`=0, `fwd_a_sel`=01. Without forwarding: `stall`=1 for three cycles, then 0.
- Issue LOAD r7, next cycle src_b=7 with forwarding -> `stall`=1 for one cycle, then `fwd_b_sel`=10.
- Issue r4 writes twice consecutively, then src_a=4 -> `fwd_a_sel`=01 (youngest). Also issue dst=0 with writes, then src_a=0 -> `stall`=0 and `fwd_a_sel`=00.
- Assert `hold` for 2 cycles with entries {EX:r2, MEM:r9} -> `stall`=1, entries unchanged, `inflight`=2 held.
- Assert `flush` with `issue_valid`=1 dst=r6 -> entry0 becomes a bubble, and next cycle src_a=6 -> no hazard.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared forwarding encodings, stage indices and the tracked
//            entry record for the hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;

    localparam logic [1:0] STAGE_EX    = 2'd0;
    localparam logic [1:0] STAGE_MEM   = 2'd1;
    localparam logic [1:0] STAGE_WB    = 2'd2;

    localparam int ENTRY_DST_W = 5;

    typedef struct packed {
        logic                   valid;
        logic                   writes;
        logic                   is_load;
        logic [ENTRY_DST_W-1:0] dst;
    } entry_t;

    // Stage index n maps onto forwarding code n+1 (EX=01, MEM=10, WB=11).
    function automatic logic [1:0] stage_to_fwd(input logic [1:0] stage);
        return stage + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Purpose  : Compares one source register against every tracked entry and
//            reports a hit plus the index of the youngest matching stage.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  entry_t [DEPTH-1:0]    entries,
    output logic                  hit,
    output logic [1:0]            stage
);

    logic [DEPTH-1:0]       w_match;
    logic [ENTRY_DST_W-1:0] w_src;

    assign w_src = ENTRY_DST_W'(src);

    // A zero source never matches, which also excludes entries whose dst is 0.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_match[gi] = src_used && (w_src != '0) &&
                                 entries[gi].valid && entries[gi].writes &&
                                 (entries[gi].dst == w_src);
        end
    endgenerate

    always_comb begin
        hit   = |w_match;
        stage = STAGE_EX;
        // Walk oldest to youngest so the youngest match is written last.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                stage = 2'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks destination registers in EX/MEM/WB and reports stall and
//            operand forwarding selects back to decode.
//            Optional macro HAZARD_FORWARD_EN: stall only on load-use and
//            drive forwarding selects; otherwise stall on any match.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic                  issue_writes,
    input  logic                  issue_is_load,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    input  logic                  src_a_used,
    input  logic                  src_b_used,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [1:0]            inflight
);

    // Datapath width only gives addressing context; no logic depends on it.
    localparam int c_unused_width = WIDTH;

    entry_t [DEPTH-1:0] r_entries;
    entry_t [DEPTH-1:0] w_next;
    logic   [1:0]       r_inflight;
    logic   [1:0]       w_count;
    logic               w_hit_a, w_hit_b;
    logic   [1:0]       w_stage_a, w_stage_b;
    logic               w_haz_a, w_haz_b;
    logic               w_take;

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_match_a (
        .src      (src_a),
        .src_used (src_a_used),
        .entries  (r_entries),
        .hit      (w_hit_a),
        .stage    (w_stage_a)
    );

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_match_b (
        .src      (src_b),
        .src_used (src_b_used),
        .entries  (r_entries),
        .hit      (w_hit_b),
        .stage    (w_stage_b)
    );

`ifdef HAZARD_FORWARD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign w_haz_a = w_hit_a && (w_stage_a == STAGE_EX) && r_entries[0].is_load;
    assign w_haz_b = w_hit_b && (w_stage_b == STAGE_EX) && r_entries[0].is_load;

    assign fwd_a_sel = (stall || flush || !w_hit_a) ? FWD_REGFILE : stage_to_fwd(w_stage_a);
    assign fwd_b_sel = (stall || flush || !w_hit_b) ? FWD_REGFILE : stage_to_fwd(w_stage_b);
`else
    logic w_unused_stage;

    assign w_haz_a        = w_hit_a;
    assign w_haz_b        = w_hit_b;
    assign w_unused_stage = ^{w_stage_a, w_stage_b};

    assign fwd_a_sel = FWD_REGFILE;
    assign fwd_b_sel = FWD_REGFILE;
`endif

    // A squashed instruction is never checked, so flush masks hazards.
    assign stall  = hold || (!flush && (w_haz_a || w_haz_b));
    assign w_take = issue_valid && !stall && !flush;

    always_comb begin
        w_next  = r_entries;
        w_count = '0;
        if (!hold) begin
            w_next[0] = '0;
            if (w_take) begin
                w_next[0].valid   = 1'b1;
                w_next[0].writes  = issue_writes;
                w_next[0].is_load = issue_is_load;
                w_next[0].dst     = ENTRY_DST_W'(issue_dst);
            end
            for (int i = 1; i < DEPTH; i++) begin
                w_next[i] = r_entries[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + 2'(w_next[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entries  <= '0;
            r_inflight <= '0;
        end else begin
            r_entries  <= w_next;
            r_inflight <= w_count;
        end
    end

    assign inflight = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed table-driven bench for hazard_scoreboard; expectations
//            cover both builds (with and without HAZARD_FORWARD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int NV = 38;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] issue_dst;
    logic       issue_writes;
    logic       issue_is_load;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       src_a_used;
    logic       src_b_used;
    logic       hold;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic [1:0] inflight;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic       iv;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic [4:0] sa;
        logic       au;
        logic [4:0] sb;
        logic       bu;
        logic       hd;
        logic       fl;
        logic       n_st;
        logic [1:0] n_fa;
        logic [1:0] n_fb;
        logic [1:0] n_inf;
        logic       f_st;
        logic [1:0] f_fa;
        logic [1:0] f_fb;
        logic [1:0] f_inf;
    } vec_t;

    vec_t tbl [NV];

    hazard_scoreboard #(
        .WIDTH      (32),
        .REG_ADDR_W (5),
        .DEPTH      (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_dst     (issue_dst),
        .issue_writes  (issue_writes),
        .issue_is_load (issue_is_load),
        .src_a         (src_a),
        .src_b         (src_b),
        .src_a_used    (src_a_used),
        .src_b_used    (src_b_used),
        .hold          (hold),
        .flush         (flush),
        .stall         (stall),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .inflight      (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int iv, int dst, int wr, int ld, int sa, int au,
                                int sb, int bu, int hd, int fl,
                                int ns, int nfa, int nfb, int ninf,
                                int fs, int ffa, int ffb, int finf);
        vec_t v;
        v.iv = 1'(iv);   v.dst = 5'(dst); v.wr = 1'(wr);   v.ld = 1'(ld);
        v.sa = 5'(sa);   v.au = 1'(au);   v.sb = 5'(sb);   v.bu = 1'(bu);
        v.hd = 1'(hd);   v.fl = 1'(fl);
        v.n_st = 1'(ns); v.n_fa = 2'(nfa); v.n_fb = 2'(nfb); v.n_inf = 2'(ninf);
        v.f_st = 1'(fs); v.f_fa = 2'(ffa); v.f_fb = 2'(ffb); v.f_inf = 2'(finf);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        issue_valid   = v.iv;
        issue_dst     = v.dst;
        issue_writes  = v.wr;
        issue_is_load = v.ld;
        src_a         = v.sa;
        src_a_used    = v.au;
        src_b         = v.sb;
        src_b_used    = v.bu;
        hold          = v.hd;
        flush         = v.fl;
    endtask

    task automatic chk(input string name, input int row, input logic [1:0] act,
                       input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //        iv dst wr ld  sa au sb bu hd fl | nf: st fa fb inf | f: st fa fb inf
        tbl[0]  = mk(0, 0, 0, 0,  5, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 3, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,  3, 1, 0, 0, 0, 0,  1, 0, 0, 1,  0, 1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0,  3, 1, 0, 0, 0, 0,  1, 0, 0, 1,  0, 2, 0, 2);
        tbl[4]  = mk(1, 0, 0, 0,  3, 1, 0, 0, 0, 0,  1, 0, 0, 1,  0, 3, 0, 3);
        tbl[5]  = mk(1, 0, 0, 0,  3, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3);
        tbl[6]  = mk(1, 7, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 3);
        tbl[7]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0, 0,  1, 0, 0, 2,  1, 0, 0, 3);
        tbl[8]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0, 0,  1, 0, 0, 2,  0, 0, 2, 2);
        tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 2);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
        tbl[12] = mk(1, 4, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[13] = mk(1, 4, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, 0,  4, 1, 4, 1, 0, 0,  1, 0, 0, 2,  0, 1, 1, 2);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 2,  0, 0, 0, 3);
        tbl[16] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 2);
        tbl[17] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
        tbl[18] = mk(1, 0, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 2,  0, 0, 0, 2);
        tbl[21] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 2,  0, 0, 0, 2);
        tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[23] = mk(1, 9, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[24] = mk(1, 2, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[25] = mk(1, 0, 0, 0,  2, 1, 9, 1, 1, 0,  1, 0, 0, 2,  1, 0, 0, 2);
        tbl[26] = mk(1, 0, 0, 0,  2, 1, 9, 1, 1, 0,  1, 0, 0, 2,  1, 0, 0, 2);
        tbl[27] = mk(0, 0, 0, 0,  2, 1, 9, 1, 0, 0,  1, 0, 0, 2,  0, 1, 2, 2);
        tbl[28] = mk(0, 0, 0, 0,  2, 1, 9, 1, 0, 0,  1, 0, 0, 2,  0, 2, 3, 2);
        tbl[29] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[30] = mk(1, 6, 1, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[31] = mk(0, 0, 0, 0,  6, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[32] = mk(1, 8, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[33] = mk(1, 8, 1, 0,  8, 1, 0, 0, 0, 1,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[34] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 1);
        tbl[35] = mk(1, 5, 1, 0,  0, 0, 0, 0, 1, 1,  1, 0, 0, 1,  1, 0, 0, 1);
        tbl[36] = mk(0, 0, 0, 0,  8, 1, 0, 0, 0, 0,  1, 0, 0, 1,  0, 3, 0, 1);
        tbl[37] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall",    -1, {1'b0, stall}, 2'd0);
        chk("reset_fwd_a",    -1, fwd_a_sel,     2'd0);
        chk("reset_inflight", -1, inflight,      2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk("stall",    i, {1'b0, stall}, FWD ? {1'b0, tbl[i].f_st} : {1'b0, tbl[i].n_st});
            chk("fwd_a",    i, fwd_a_sel,     FWD ? tbl[i].f_fa  : tbl[i].n_fa);
            chk("fwd_b",    i, fwd_b_sel,     FWD ? tbl[i].f_fb  : tbl[i].n_fb);
            chk("inflight", i, inflight,      FWD ? tbl[i].f_inf : tbl[i].n_inf);
        end

        // Asynchronous reset mid-stream drops the in-flight r3 immediately.
        @(negedge clk);
        drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_stall",    100, {1'b0, stall}, FWD ? 2'd0 : 2'd1);
        chk("pre_rst_fwd_a",    100, fwd_a_sel,     FWD ? 2'd1 : 2'd0);
        chk("pre_rst_inflight", 100, inflight,      2'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall",    101, {1'b0, stall}, 2'd0);
        chk("async_rst_fwd_a",    101, fwd_a_sel,     2'd0);
        chk("async_rst_inflight", 101, inflight,      2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_stall",    102, {1'b0, stall}, 2'd0);
        chk("post_rst_inflight", 102, inflight,      2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
